// File: rtl/qos_wrr_switch.sv
// QoS switch: classifies words into per-class queues and drains them through a
// weighted round-robin arbiter into a registered valid/ready output stage.
module qos_wrr_switch #(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 12,
   parameter int DEPTH    = 8,
   parameter int WEIGHT_W = 3,
   parameter int CNT_W    = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       init,
   input  logic [$clog2(DEPTH):0]     umbral_high,
   input  logic [$clog2(DEPTH):0]     umbral_low,
   input  logic [N_CH*WEIGHT_W-1:0]   weights,
   input  logic                       push,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(N_CH)-1:0]    out_class,
   output logic [N_CH-1:0]            almost_full,
   output logic [N_CH-1:0]            almost_empty,
   output logic [N_CH-1:0]            full,
   output logic                       active_out,
   output logic                       idle_out,
   output logic                       error_out,
   input  logic                       req,
   input  logic [2:0]                 idx,
   output logic                       valid,
   output logic [CNT_W-1:0]           data
);

   localparam int CLS_W = $clog2(N_CH);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;

   typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;

   state_t                    state_q, state_d;
   logic [DATA_W-1:0]         mem_q [N_CH][DEPTH];
   logic [AW-1:0]             wrPtr_q [N_CH];
   logic [AW-1:0]             rdPtr_q [N_CH];
   logic [CW-1:0]             count_q [N_CH];
   logic [CNT_W-1:0]          popCnt_q [N_CH];
   logic [CW-1:0]             highThr_q, lowThr_q;
   logic [N_CH*WEIGHT_W-1:0]  weights_q;
   logic [CLS_W-1:0]          cur_q, cur_d;
   logic [WEIGHT_W-1:0]       credit_q, credit_d;
   logic                      outValid_q;
   logic [DATA_W-1:0]         outData_q;
   logic [CLS_W-1:0]          outClass_q;
   logic                      valid_q;
   logic [CNT_W-1:0]          data_q;

   logic                      run;
   logic [N_CH-1:0]           nonEmpty;
   logic [CLS_W-1:0]          grant;
   logic                      grantVld;
   logic                      pop;
   logic [CLS_W-1:0]          pushCls;
   logic                      pushOk, overflow, pushWe;
   logic [WEIGHT_W-1:0]       grantWeight, newCredit;
   logic [N_CH-1:0]           incVec, decVec;
   logic [CNT_W-1:0]          rdData;

   assign run     = (state_q == S_IDLE) || (state_q == S_ACTIVE);
   assign pushCls = data_in[DATA_W-1 -: CLS_W];

   // Per-class status is decoded straight from the registered occupancy counts.
   always_comb begin
      nonEmpty     = '0;
      full         = '0;
      almost_full  = '0;
      almost_empty = '0;
      for (int c = 0; c < N_CH; c++) begin
         nonEmpty[c]     = (count_q[c] != '0);
         full[c]         = (count_q[c] == CW'(DEPTH));
         almost_full[c]  = (count_q[c] >= highThr_q);
         almost_empty[c] = (count_q[c] <= lowThr_q);
      end
   end

   // The current class keeps the grant while it has credit; otherwise scan
   // forward from cur+1 so that cur itself is the last candidate.
   always_comb begin
      grant    = '0;
      grantVld = 1'b0;
      if (nonEmpty[cur_q] && (credit_q != '0)) begin
         grant    = cur_q;
         grantVld = 1'b1;
      end else begin
         for (int k = 1; k <= N_CH; k++) begin
            if (!grantVld && nonEmpty[cur_q + CLS_W'(k)]) begin
               grant    = cur_q + CLS_W'(k);
               grantVld = 1'b1;
            end
         end
      end
   end

   assign pop      = run && (!outValid_q || out_ready) && grantVld;
   assign pushOk   = push && run;
   assign overflow = pushOk && full[pushCls] && !(pop && (grant == pushCls));
   assign pushWe   = pushOk && !overflow;

   assign grantWeight = weights_q[grant*WEIGHT_W +: WEIGHT_W];
   assign newCredit   = (grantWeight == '0) ? '0 : grantWeight - 1'b1;

   always_comb begin
      incVec = '0;
      decVec = '0;
      if (pushWe) incVec[pushCls] = 1'b1;
      if (pop)    decVec[grant]   = 1'b1;
   end

   // A fresh grant (new class, or cur re-won by the scan) reloads the credit.
   always_comb begin
      cur_d    = cur_q;
      credit_d = credit_q;
      if (pop) begin
         if ((grant == cur_q) && (credit_q != '0)) begin
            credit_d = credit_q - 1'b1;
         end else begin
            cur_d    = grant;
            credit_d = newCredit;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:  state_d = S_INIT;
         S_INIT:   if (!init) state_d = S_IDLE;
         S_IDLE: begin
            if (overflow)       state_d = S_ERROR;
            else if (init)      state_d = S_INIT;
            else if (|nonEmpty) state_d = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (overflow)                        state_d = S_ERROR;
            else if (!(|nonEmpty) && !outValid_q) state_d = S_IDLE;
         end
         S_ERROR:  state_d = S_ERROR;
         default:  state_d = S_RESET;
      endcase
   end

   always_comb begin
      rdData = '0;
      if ({1'b0, idx} < 4'(N_CH)) rdData = popCnt_q[idx[CLS_W-1:0]];
   end

   // Queue storage holds no reset; the counts alone define what is valid.
   always_ff @(posedge clk) begin
      if (pushWe) mem_q[pushCls][wrPtr_q[pushCls]] <= data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_RESET;
         cur_q      <= CLS_W'(N_CH - 1);
         credit_q   <= '0;
         highThr_q  <= CW'(DEPTH - 1);
         lowThr_q   <= CW'(1);
         weights_q  <= {N_CH{WEIGHT_W'(1)}};
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outClass_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         for (int c = 0; c < N_CH; c++) begin
            wrPtr_q[c]  <= '0;
            rdPtr_q[c]  <= '0;
            count_q[c]  <= '0;
            popCnt_q[c] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         credit_q <= credit_d;
         if (state_q == S_INIT) begin
            highThr_q <= umbral_high;
            lowThr_q  <= umbral_low;
            weights_q <= weights;
         end
         for (int c = 0; c < N_CH; c++) begin
            if (incVec[c]) wrPtr_q[c] <= wrPtr_q[c] + 1'b1;
            if (decVec[c]) begin
               rdPtr_q[c]  <= rdPtr_q[c] + 1'b1;
               popCnt_q[c] <= popCnt_q[c] + 1'b1;
            end
            if (incVec[c] && !decVec[c])      count_q[c] <= count_q[c] + 1'b1;
            else if (decVec[c] && !incVec[c]) count_q[c] <= count_q[c] - 1'b1;
         end
         if (pop) begin
            outValid_q <= 1'b1;
            outData_q  <= mem_q[grant][rdPtr_q[grant]];
            outClass_q <= grant;
         end else if (out_ready && (state_q != S_ERROR)) begin
            outValid_q <= 1'b0;
         end
         valid_q <= req;
         if (req) data_q <= rdData;
      end
   end

   assign out_valid  = outValid_q;
   assign out_data   = outData_q;
   assign out_class  = outClass_q;
   assign valid      = valid_q;
   assign data       = data_q;
   assign active_out = (state_q == S_ACTIVE);
   assign idle_out   = (state_q == S_IDLE);
   assign error_out  = (state_q == S_ERROR);

endmodule

// File: tb/tb_qos_wrr_switch.sv
// Directed self-checking bench for qos_wrr_switch with the default parameters.
module tb_qos_wrr_switch;

   logic        clk = 1'b0;
   logic        reset;
   logic        init;
   logic [3:0]  umbralHigh;
   logic [3:0]  umbralLow;
   logic [11:0] weights;
   logic        push;
   logic [11:0] dataIn;
   logic        outReady;
   logic        outValid;
   logic [11:0] outData;
   logic [1:0]  outClass;
   logic [3:0]  almostFull;
   logic [3:0]  almostEmpty;
   logic [3:0]  full;
   logic        activeOut;
   logic        idleOut;
   logic        errorOut;
   logic        req;
   logic [2:0]  idx;
   logic        valid;
   logic [4:0]  data;

   int testCount = 0;
   int failCount = 0;

   logic [1:0]  expCls  [8];
   logic [11:0] expData [8];

   qos_wrr_switch dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .umbral_high  (umbralHigh),
      .umbral_low   (umbralLow),
      .weights      (weights),
      .push         (push),
      .data_in      (dataIn),
      .out_ready    (outReady),
      .out_valid    (outValid),
      .out_data     (outData),
      .out_class    (outClass),
      .almost_full  (almostFull),
      .almost_empty (almostEmpty),
      .full         (full),
      .active_out   (activeOut),
      .idle_out     (idleOut),
      .error_out    (errorOut),
      .req          (req),
      .idx          (idx),
      .valid        (valid),
      .data         (data)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [11:0] word);
      push   = 1'b1;
      dataIn = word;
      tick();
      push   = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reset, pass through INIT with the given configuration, land in IDLE.
   task automatic initSequence(input logic [3:0] uh, input logic [3:0] ul, input logic [11:0] w);
      reset      = 1'b0;
      umbralHigh = uh;
      umbralLow  = ul;
      weights    = w;
      init       = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      tick();
      init = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      expCls  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
      expData = '{12'h001, 12'h002, 12'h003, 12'h401, 12'h004, 12'h402, 12'h403, 12'h404};

      reset      = 1'b0;
      init       = 1'b0;
      umbralHigh = 4'd7;
      umbralLow  = 4'd1;
      weights    = 12'b001_001_001_001;
      push       = 1'b0;
      dataIn     = '0;
      outReady   = 1'b0;
      req        = 1'b0;
      idx        = '0;
      tick();
      tick();

      checkOutput("rst_outValid",    32'(outValid),    32'd0);
      checkOutput("rst_outData",     32'(outData),     32'd0);
      checkOutput("rst_outClass",    32'(outClass),    32'd0);
      checkOutput("rst_full",        32'(full),        32'd0);
      checkOutput("rst_almostFull",  32'(almostFull),  32'd0);
      checkOutput("rst_almostEmpty", 32'(almostEmpty), 32'hF);
      checkOutput("rst_flags",       32'({activeOut, idleOut, errorOut}), 32'd0);
      checkOutput("rst_valid",       32'(valid),       32'd0);
      checkOutput("rst_data",        32'(data),        32'd0);

      reset = 1'b1;
      tick();
      checkOutput("init_notIdle", 32'(idleOut), 32'd0);
      tick();
      checkOutput("idle_after2", 32'(idleOut), 32'd1);

      // Single word latency through an empty queue and free output stage.
      outReady = 1'b1;
      applyStimulus(12'h8A5);
      checkOutput("lat_notYet", 32'(outValid), 32'd0);
      tick();
      checkOutput("lat_outValid",  32'(outValid),  32'd1);
      checkOutput("lat_outData",   32'(outData),   32'h8A5);
      checkOutput("lat_outClass",  32'(outClass),  32'd2);
      checkOutput("lat_activeOut", 32'(activeOut), 32'd1);
      tick();
      checkOutput("lat_drained", 32'(outValid), 32'd0);
      tick();
      checkOutput("lat_idleBack", 32'(idleOut), 32'd1);

      // Asynchronous reset while data sits in the output stage and a queue.
      outReady = 1'b0;
      applyStimulus(12'h123);
      applyStimulus(12'h456);
      tick();
      checkOutput("traf_active",   32'(activeOut), 32'd1);
      checkOutput("traf_outValid", 32'(outValid),  32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst_outValid",    32'(outValid),    32'd0);
      checkOutput("arst_outData",     32'(outData),     32'd0);
      checkOutput("arst_almostEmpty", 32'(almostEmpty), 32'hF);
      checkOutput("arst_active",      32'(activeOut),   32'd0);

      // WRR with w0=3, w1=1.
      initSequence(4'd7, 4'd1, 12'b001_001_001_011);
      checkOutput("wrr_idle", 32'(idleOut), 32'd1);
      outReady = 1'b0;
      for (int i = 1; i <= 4; i++) applyStimulus(12'h000 + 12'(i));
      for (int i = 1; i <= 4; i++) applyStimulus(12'h400 + 12'(i));
      outReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) tick();
         checkOutput($sformatf("wrr_valid%0d", i), 32'(outValid), 32'd1);
         checkOutput($sformatf("wrr_class%0d", i), 32'(outClass), 32'(expCls[i]));
         checkOutput($sformatf("wrr_data%0d", i),  32'(outData),  32'(expData[i]));
      end
      tick();
      checkOutput("wrr_empty", 32'(outValid), 32'd0);
      tick();
      checkOutput("wrr_idleBack", 32'(idleOut), 32'd1);

      // Pop counter reads.
      req = 1'b1;
      idx = 3'd0;
      tick();
      checkOutput("cnt_valid0", 32'(valid), 32'd1);
      checkOutput("cnt_idx0",   32'(data),  32'd4);
      idx = 3'd1;
      tick();
      checkOutput("cnt_idx1", 32'(data), 32'd4);
      idx = 3'd2;
      tick();
      checkOutput("cnt_idx2", 32'(data), 32'd0);
      idx = 3'd5;
      tick();
      checkOutput("cnt_idx5", 32'(data), 32'd0);
      req = 1'b0;
      tick();
      checkOutput("cnt_validLow", 32'(valid), 32'd0);

      // Thresholds: high=6, low=2 on class 1.
      initSequence(4'd6, 4'd2, 12'b001_001_001_001);
      outReady = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus(12'h400 + 12'(i));
      checkOutput("thr_below_af", 32'(almostFull), 32'h0);
      applyStimulus(12'h406);
      checkOutput("thr_af",   32'(almostFull),  32'b0010);
      checkOutput("thr_ae",   32'(almostEmpty), 32'b1101);
      checkOutput("thr_full", 32'(full),        32'h0);
      outReady = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("thr_cnt3_ae", 32'(almostEmpty), 32'b1101);
      tick();
      outReady = 1'b0;
      checkOutput("thr_cnt2_ae", 32'(almostEmpty), 32'b1111);
      checkOutput("thr_cnt2_af", 32'(almostFull),  32'h0);

      // Overflow on class 3 with the output stage blocked.
      initSequence(4'd7, 4'd1, 12'b001_001_001_001);
      outReady = 1'b0;
      for (int i = 0; i < 9; i++) applyStimulus(12'hC00 + 12'(i));
      checkOutput("ovf_full9",    32'(full),      32'b1000);
      checkOutput("ovf_noErr9",   32'(errorOut),  32'd0);
      checkOutput("ovf_active9",  32'(activeOut), 32'd1);
      applyStimulus(12'hC09);
      checkOutput("ovf_error",    32'(errorOut),  32'd1);
      checkOutput("ovf_inactive", 32'(activeOut), 32'd0);
      outReady = 1'b1;
      applyStimulus(12'hC55);
      tick();
      checkOutput("ovf_holdValid", 32'(outValid), 32'd1);
      checkOutput("ovf_holdData",  32'(outData),  32'hC00);
      checkOutput("ovf_holdFull",  32'(full),     32'b1000);
      checkOutput("ovf_sticky",    32'(errorOut), 32'd1);

      // Streaming 33 words through class 0 wraps its pop counter to 1.
      initSequence(4'd7, 4'd1, 12'b001_001_001_001);
      outReady = 1'b1;
      for (int i = 0; i < 33; i++) applyStimulus(12'(i));
      checkOutput("str_valid", 32'(outValid), 32'd1);
      checkOutput("str_data",  32'(outData),  32'h01F);
      tick();
      checkOutput("str_last",  32'(outData),  32'h020);
      tick();
      tick();
      req = 1'b1;
      idx = 3'd0;
      tick();
      checkOutput("wrap_valid", 32'(valid), 32'd1);
      checkOutput("wrap_idx0",  32'(data),  32'd1);
      req = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
